ce_frac_gen: RTL

//  Multi-channel fractional clock-enable generator for arcade cores; replaces the fixed

---
 rtl/ce_gen_pkg.sv | 18 +
 rtl/ce_frac_ch.sv | 120 ++++++++++++
 rtl/ce_frac_gen.sv | 57 +++++
 3 files changed

// File: rtl/ce_gen_pkg.sv
// Shared constants and types for the fractional clock-enable generator.
// Defaults target a 24 MHz clk_sys: ch0 = 1/4 (6M), ch1 = 1/6 (4M), ch2 = 179/2400 (1M79).
package ce_gen_pkg;

  localparam int unsigned CE_NUM_CH = 3;
  localparam int unsigned CE_ACC_W  = 16;

  // ch0 occupies the least significant ACC_W bits
  localparam logic [CE_NUM_CH*CE_ACC_W-1:0] CE_DEF_NUM = {16'd179,  16'd1, 16'd1};
  localparam logic [CE_NUM_CH*CE_ACC_W-1:0] CE_DEF_DEN = {16'd2400, 16'd6, 16'd4};

  // Rate configuration word for one channel
  typedef struct packed {
    logic [CE_ACC_W-1:0] num;
    logic [CE_ACC_W-1:0] den;
  } ce_cfg_t;

endpackage

// File: rtl/ce_frac_ch.sv
// One fractional clock-enable channel: accumulator, live rate, shadow rate and apply logic.
// Ports:
//   clk_sys, reset_n         clock, synchronous active-low reset
//   pause                    freeze accumulator, hold ce low, defer applies
//   resync                   clear accumulator, apply any pending shadow now
//   cfg_wr, cfg_num/cfg_den  load shadow rate (already decoded for this channel)
//   cfg_pending              shadow waiting to be applied
//   cfg_ack                  one-cycle pulse when the shadow becomes live
//   ce                       registered clock-enable pulse
module ce_frac_ch #(
  parameter int unsigned       ACC_W   = 16,
  parameter logic [ACC_W-1:0]  DEF_NUM = ACC_W'(1),
  parameter logic [ACC_W-1:0]  DEF_DEN = ACC_W'(4)
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             pause,
  input  logic             resync,
  input  logic             cfg_wr,
  input  logic [ACC_W-1:0] cfg_num,
  input  logic [ACC_W-1:0] cfg_den,
  output logic             cfg_pending,
  output logic             cfg_ack,
  output logic             ce
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] num_q, num_d;
  logic [ACC_W-1:0] den_q, den_d;
  logic [ACC_W-1:0] sh_num_q, sh_num_d;
  logic [ACC_W-1:0] sh_den_q, sh_den_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic             ce_q, ce_d;

  logic             dis_c;
  logic [ACC_W-1:0] num_eff_c;
  logic [ACC_W:0]   sum_c;
  logic             cross_c;
  logic             apply_c;

  // Effective rate and crossing detect; num is clamped to den so ce never exceeds one per cycle
  always_comb begin
    dis_c     = (num_q == '0) || (den_q == '0);
    num_eff_c = (num_q > den_q) ? den_q : num_q;
    sum_c     = {1'b0, acc_q} + {1'b0, num_eff_c};
    cross_c   = !dis_c && (sum_c >= {1'b0, den_q});
  end

  // Next state: accumulate, apply shadow on crossing/disabled/resync, capture writes last
  always_comb begin
    acc_d    = acc_q;
    num_d    = num_q;
    den_d    = den_q;
    sh_num_d = sh_num_q;
    sh_den_d = sh_den_q;
    pend_d   = pend_q;
    ack_d    = 1'b0;
    ce_d     = 1'b0;
    apply_c  = 1'b0;

    if (resync) begin
      acc_d   = '0;
      apply_c = pend_q;
    end else if (!pause) begin
      if (dis_c) begin
        acc_d   = '0;
        apply_c = pend_q;
      end else if (cross_c) begin
        // remainder is kept so a rate change does not disturb phase
        acc_d   = ACC_W'(sum_c - {1'b0, den_q});
        ce_d    = 1'b1;
        apply_c = pend_q;
      end else begin
        acc_d = ACC_W'(sum_c);
      end
    end

    if (apply_c) begin
      num_d  = sh_num_q;
      den_d  = sh_den_q;
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end

    // a write on the apply cycle re-arms pending with the new value
    if (cfg_wr) begin
      sh_num_d = cfg_num;
      sh_den_d = cfg_den;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      acc_q    <= '0;
      num_q    <= DEF_NUM;
      den_q    <= DEF_DEN;
      sh_num_q <= '0;
      sh_den_q <= '0;
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
      ce_q     <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      num_q    <= num_d;
      den_q    <= den_d;
      sh_num_q <= sh_num_d;
      sh_den_q <= sh_den_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      ce_q     <= ce_d;
    end
  end

  assign cfg_pending = pend_q;
  assign cfg_ack     = ack_q;
  assign ce          = ce_q;

endmodule

// File: rtl/ce_frac_gen.sv
// Multi-channel fractional clock-enable generator. Each channel pulses ce at an average
// rate of f_clk_sys*NUM/DEN; rates are reloadable at runtime through a shadow register.
// Ports:
//   clk_sys, reset_n   clock, synchronous active-low reset
//   pause, resync      broadcast to all channels
//   cfg_wr/cfg_ch      config write strobe and target channel (out-of-range ignored)
//   cfg_num/cfg_den    new rate
//   cfg_pending        per channel shadow waiting
//   cfg_ack            per channel apply pulse
//   ce                 per channel registered clock-enable
module ce_frac_gen
  import ce_gen_pkg::*;
#(
  parameter int unsigned                    NUM_CH  = CE_NUM_CH,
  parameter int unsigned                    ACC_W   = CE_ACC_W,
  parameter logic [NUM_CH*ACC_W-1:0]        DEF_NUM = CE_DEF_NUM,
  parameter logic [NUM_CH*ACC_W-1:0]        DEF_DEN = CE_DEF_DEN,
  localparam int unsigned                   CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              pause,
  input  logic              resync,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_num,
  input  logic [ACC_W-1:0]  cfg_den,
  output logic [NUM_CH-1:0] cfg_pending,
  output logic [NUM_CH-1:0] cfg_ack,
  output logic [NUM_CH-1:0] ce
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_c;

    // channel-local write strobe; codes >= NUM_CH match no channel
    always_comb wr_c = cfg_wr && (cfg_ch == CH_W'(i));

    ce_frac_ch #(
      .ACC_W   (ACC_W),
      .DEF_NUM (DEF_NUM[i*ACC_W +: ACC_W]),
      .DEF_DEN (DEF_DEN[i*ACC_W +: ACC_W])
    ) u_ch (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .pause       (pause),
      .resync      (resync),
      .cfg_wr      (wr_c),
      .cfg_num     (cfg_num),
      .cfg_den     (cfg_den),
      .cfg_pending (cfg_pending[i]),
      .cfg_ack     (cfg_ack[i]),
      .ce          (ce[i])
    );
  end

endmodule
